instr_mem_pipelined: RTL and testbench

Parametrised instruction memory for the core's fetch stage. It generalises the single-port combinational-read memory into three pieces:
- a registered fetch port with a request/response handshake and backpressure;
- a byte-enabled loader write port;
- address-fault reporting and an optional clear-on-reset sweep.

It sits between the fetch unit (read side) and the program loader/testbench driver (write side).

---
 rtl/imem_pkg.sv | 48 ++++
 rtl/imem_sram.sv | 36 +++
 rtl/instr_mem_pipelined.sv | 146 ++++++++++++++
 tb/tb_instr_mem_pipelined.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and address decode for the pipelined instruction memory.
package imem_pkg;

  typedef enum logic {
    IMEM_INIT,
    IMEM_READY
  } imem_state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_RANGE    = 2'd2;

  // Decode works on a zero-extended 64-bit byte address so one function
  // serves every ADDR_W / DATA_W / DEPTH combination.
  localparam int unsigned DEC_ADDR_W = 64;
  localparam int unsigned DEC_IDX_W  = 32;

  typedef struct packed {
    logic                 fault;
    logic [1:0]           cause;
    logic [DEC_IDX_W-1:0] index;
  } imem_dec_t;

  // Misalignment is checked first so it wins over an out-of-range address.
  function automatic imem_dec_t imem_decode(input logic [DEC_ADDR_W-1:0] addr,
                                            input int unsigned off_w,
                                            input int unsigned idx_w);
    imem_dec_t             d;
    logic [DEC_ADDR_W-1:0] off_mask;
    logic [DEC_ADDR_W-1:0] idx_mask;
    logic [DEC_ADDR_W-1:0] word;
    off_mask = (64'd1 << off_w) - 64'd1;
    idx_mask = (64'd1 << idx_w) - 64'd1;
    word     = addr >> off_w;
    d.index  = DEC_IDX_W'(word & idx_mask);
    d.fault  = 1'b0;
    d.cause  = CAUSE_NONE;
    if ((addr & off_mask) != 64'd0) begin
      d.fault = 1'b1;
      d.cause = CAUSE_MISALIGN;
    end else if ((word >> idx_w) != 64'd0) begin
      d.fault = 1'b1;
      d.cause = CAUSE_RANGE;
    end
    return d;
  endfunction

endpackage

// File: rtl/imem_sram.sv
// DEPTH x DATA_W synchronous RAM, one byte-enabled write port, one read port.
// A read and write to the same word in one cycle returns the old contents.
module imem_sram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_widx,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wbe,
  input  logic                i_re,
  input  logic [IDX_W-1:0]    i_ridx,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Byte-lane writes and read-first registered read; the read register only
  // loads when enabled so it holds a stalled response.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wbe[b]) r_mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_ridx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_pipelined.sv
// Fetch-stage instruction memory: registered fetch port with backpressure,
// byte-enabled loader port, address fault reporting and a clear sweep.
//
//  state      | meaning
//  -----------+-------------------------------------------------------
//  IMEM_INIT  | zeroing one word per cycle, fetch and writes blocked
//  IMEM_READY | memory usable; left only through rst
module instr_mem_pipelined
  import imem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_fault,
  output logic [1:0]          rsp_cause,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic                wr_ready,
  output logic                init_done
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  imem_state_e r_state;
  imem_state_e w_state_nxt;
  logic [IDX_W-1:0] r_clr_idx;

  logic        r_rsp_valid;
  logic        r_rsp_hit;
  logic        r_rsp_fault;
  logic [1:0]  r_rsp_cause;

  imem_dec_t   w_rd_dec;
  imem_dec_t   w_wr_dec;
  logic        w_accept;
  logic        w_init_done;
  logic        w_wr_ready;
  logic        w_mem_we;
  logic [IDX_W-1:0]    w_mem_widx;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [DATA_W/8-1:0] w_mem_wbe;
  logic [DATA_W-1:0]   w_ram_q;
  logic        w_unused_idx_bits;

  assign w_rd_dec = imem_decode(DEC_ADDR_W'(req_addr), OFF_W, IDX_W);
  assign w_wr_dec = imem_decode(DEC_ADDR_W'(wr_addr), OFF_W, IDX_W);
  assign w_unused_idx_bits = ^{w_rd_dec.index[DEC_IDX_W-1:IDX_W],
                               w_wr_dec.index[DEC_IDX_W-1:IDX_W]};

  // Gated with rst so nothing is accepted at an edge that resets the port.
  assign req_ready = (r_state == IMEM_READY) && !rst && (!r_rsp_valid || rsp_ready);
  assign w_accept  = req_valid && req_ready;

  // State register and clear counter; reset restarts any sweep from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? IMEM_INIT : IMEM_READY;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IMEM_INIT) r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  // Next state and the single RAM write port: sweep zeros in INIT, loader in READY.
  always_comb begin
    w_state_nxt = r_state;
    w_init_done = 1'b0;
    w_wr_ready  = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_widx  = r_clr_idx;
    w_mem_wdata = '0;
    w_mem_wbe   = '1;
    case (r_state)
      IMEM_INIT: begin
        w_mem_we = 1'b1;
        if (r_clr_idx == LAST_IDX) w_state_nxt = IMEM_READY;
      end
      IMEM_READY: begin
        w_init_done = 1'b1;
        w_wr_ready  = 1'b1;
        w_mem_we    = wr_en && !w_wr_dec.fault;
        w_mem_widx  = w_wr_dec.index[IDX_W-1:0];
        w_mem_wdata = wr_data;
        w_mem_wbe   = wr_be;
      end
      default: w_state_nxt = IMEM_READY;
    endcase
  end

  assign init_done = w_init_done;
  assign wr_ready  = w_wr_ready;

  // Response control; the data itself lives in the RAM read register, which
  // only loads on a non-faulting accept and therefore holds during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_cause <= CAUSE_NONE;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_hit   <= !w_rd_dec.fault;
      r_rsp_fault <= w_rd_dec.fault;
      r_rsp_cause <= w_rd_dec.cause;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  imem_sram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_widx  (w_mem_widx),
    .i_wdata (w_mem_wdata),
    .i_wbe   (w_mem_wbe),
    .i_re    (w_accept && !w_rd_dec.fault),
    .i_ridx  (w_rd_dec.index[IDX_W-1:0]),
    .o_rdata (w_ram_q)
  );

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_hit ? w_ram_q : '0;
  assign rsp_fault = r_rsp_fault;
  assign rsp_cause = r_rsp_cause;

endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Bench for instr_mem_pipelined: DEPTH=16 instance with clear sweep driven
// through a response scoreboard, plus a CLEAR_ON_RESET=0 instance for
// retention across reset.
module tb_instr_mem_pipelined;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance A: DEPTH=16, CLEAR_ON_RESET=1
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault;
  logic [31:0] req_addr, rsp_data, wr_addr, wr_data;
  logic [1:0]  rsp_cause;
  logic        wr_en, wr_ready, init_done;
  logic [3:0]  wr_be;

  // instance B: DEPTH=16, CLEAR_ON_RESET=0
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_fault;
  logic [31:0] b_req_addr, b_rsp_data, b_wr_addr, b_wr_data;
  logic [1:0]  b_rsp_cause;
  logic        b_wr_en, b_wr_ready, b_init_done;
  logic [3:0]  b_wr_be;

  instr_mem_pipelined #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_fault(rsp_fault), .rsp_cause(rsp_cause),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_ready(wr_ready), .init_done(init_done)
  );

  instr_mem_pipelined #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_addr(b_req_addr), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .rsp_fault(b_rsp_fault), .rsp_cause(b_rsp_cause),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
    .wr_ready(b_wr_ready), .init_done(b_init_done)
  );

  typedef struct {
    logic [31:0] data;
    logic        fault;
    logic [1:0]  cause;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
    logic [1:0]  cause;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  rsp_t exp_q [$];
  int   rsp_cyc [$];
  logic [31:0] exp_mem [16];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Response monitor: every consumed response is matched against the queue.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_t e;
      total++;
      rsp_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected got=%h/%0d/%0d", rsp_data, rsp_fault, rsp_cause);
      end else begin
        e = exp_q.pop_front();
        if (rsp_data !== e.data || rsp_fault !== e.fault || rsp_cause !== e.cause) begin
          bad++;
          $display("FAIL rsp got=%h/%0d/%0d exp=%h/%0d/%0d",
                   rsp_data, rsp_fault, rsp_cause, e.data, e.fault, e.cause);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_accept(input string name);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=no_accept exp=accept", name);
    end
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] d,
                       input logic f, input logic [1:0] c);
    rsp_t e;
    e.data = d; e.fault = f; e.cause = c;
    req_valid = 1'b1;
    req_addr  = addr;
    exp_q.push_back(e);
    wait_accept("fetch");
    req_valid = 1'b0;
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
    int n;
    wr_en = 1'b1; wr_addr = addr; wr_data = d; wr_be = be;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_ready && n < 50);
    tick();
    wr_en = 1'b0;
    if (addr[1:0] == 2'b00 && addr < 32'h40) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) exp_mem[addr[5:2]][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    check(name, exp_q.size(), 0);
  endtask

  task automatic count_init(input string name);
    int n;
    n = 0;
    while (!init_done && n < 60) begin
      tick();
      n++;
    end
    check(name, n, 16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    vecs[0] = '{32'h0000_0006, 32'h0,          1'b1, 2'd1};
    vecs[1] = '{32'h0000_0040, 32'h0,          1'b1, 2'd2};
    vecs[2] = '{32'h0000_0042, 32'h0,          1'b1, 2'd1};
    vecs[3] = '{32'h0000_003C, 32'h0,          1'b0, 2'd0};
    vecs[4] = '{32'h0000_0008, 32'hDEADBEAA,   1'b0, 2'd0};
    vecs[5] = '{32'h0000_0001, 32'h0,          1'b1, 2'd1};
    vecs[6] = '{32'hFFFF_FFFC, 32'h0,          1'b1, 2'd2};

    for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b1;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_be = '0;

    // reset values
    tick(); tick();
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_fault_cause", {rsp_fault, rsp_cause}, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("b_rst_init_done", b_init_done, 1);
    check("b_rst_req_ready", b_req_ready, 0);
    tick();
    rst = 1'b0;
    count_init("init_latency");
    check("init_wr_ready", wr_ready, 1);

    // cleared word, then byte-enabled writes
    fetch(32'h0, 32'h0, 1'b0, 2'd0);
    drain("drain_first");
    write(32'h8, 32'hDEADBEEF, 4'hF);
    write(32'h8, 32'h000000AA, 4'h1);
    fetch(32'h8, 32'hDEADBEAA, 1'b0, 2'd0);
    drain("drain_be");

    // back-to-back fetches
    rsp_cyc.delete();
    fetch(32'h0, 32'h0, 1'b0, 2'd0);
    fetch(32'h4, 32'h0, 1'b0, 2'd0);
    fetch(32'h8, 32'hDEADBEAA, 1'b0, 2'd0);
    drain("drain_b2b");
    check("b2b_count", rsp_cyc.size(), 3);
    if (rsp_cyc.size() == 3) begin
      check("b2b_gap1", rsp_cyc[1] - rsp_cyc[0], 1);
      check("b2b_gap2", rsp_cyc[2] - rsp_cyc[1], 1);
    end

    // backpressure
    write(32'h4, 32'h12345678, 4'hF);
    write(32'hC, 32'hCAFEF00D, 4'hF);
    rsp_cyc.delete();
    rsp_ready = 1'b0;
    fetch(32'h4, 32'h12345678, 1'b0, 2'd0);
    begin
      rsp_t e;
      e.data = 32'hCAFEF00D; e.fault = 1'b0; e.cause = 2'd0;
      req_valid = 1'b1; req_addr = 32'hC;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 0);
      check("bp_rsp_data", rsp_data, 32'h12345678);
      tick();
    end
    rsp_ready = 1'b1;
    wait_accept("bp_release");
    req_valid = 1'b0;
    drain("drain_bp");
    check("bp_count", rsp_cyc.size(), 2);

    // fault table
    foreach (vecs[i]) fetch(vecs[i].addr, vecs[i].data, vecs[i].fault, vecs[i].cause);
    drain("drain_faults");

    // faulting writes must not touch memory
    write(32'h40, 32'hFFFFFFFF, 4'hF);
    write(32'h6, 32'hFFFFFFFF, 4'hF);
    for (int i = 0; i < 16; i++) fetch(32'(i * 4), exp_mem[i], 1'b0, 2'd0);
    drain("drain_scan");

    // same-cycle write and fetch: read-first
    write(32'h4, 32'h11111111, 4'hF);
    begin
      rsp_t e;
      e.data = 32'h11111111; e.fault = 1'b0; e.cause = 2'd0;
      wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'h22222222; wr_be = 4'hF;
      req_valid = 1'b1; req_addr = 32'h4;
      exp_q.push_back(e);
      @(negedge clk);
      check("rf_both_ready", {req_ready, wr_ready}, 2'b11);
      tick();
      wr_en = 1'b0; req_valid = 1'b0;
      exp_mem[1] = 32'h22222222;
    end
    fetch(32'h4, 32'h22222222, 1'b0, 2'd0);
    drain("drain_rf");

    // instance B: write before the reset, read back after
    b_wr_en = 1'b1; b_wr_addr = 32'h10; b_wr_data = 32'hA5A5A5A5; b_wr_be = 4'hF;
    @(negedge clk);
    check("b_wr_ready", b_wr_ready, 1);
    tick();
    b_wr_en = 1'b0;

    // reset with a pending response
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h4;
    wait_accept("pend");
    req_valid = 1'b0;
    @(negedge clk);
    check("pend_valid", rsp_valid, 1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_drop_valid", rsp_valid, 0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;

    // reset mid-sweep restarts it
    repeat (8) tick();
    check("mid_sweep_init_done", init_done, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_init("restart_latency");
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
    fetch(32'h4, 32'h0, 1'b0, 2'd0);
    fetch(32'h8, 32'h0, 1'b0, 2'd0);
    drain("drain_after_clear");

    // instance B retained its contents
    b_req_valid = 1'b1; b_req_addr = 32'h10;
    @(negedge clk);
    check("b_req_ready", b_req_ready, 1);
    tick();
    b_req_valid = 1'b0;
    @(negedge clk);
    check("b_rsp_valid", b_rsp_valid, 1);
    check("b_retained", b_rsp_data, 32'hA5A5A5A5);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
